cac_seq_restore_unit: RTL and testbench
=======================================

// Module: cac_seq_restore_unit
// PURPOSE
// - Parametrised, sequential corrupt-and-correct restore stage for locked combinational netlists.
// - Holds a KW-bit secret key, loaded serially after reset rather than driven on parallel key pins.
// - Compares the protected input vector against the loaded key.
// - On a match while armed, flips the MASK-selected outputs of the stripped netlist, restoring correct function.
// - Sits between the stripped netlist outputs and the chip outputs; owns key-load sequencing and a reload lockout.
// PARAMETERS
// KW         32        key width = number of protected primary inputs compared
// NOUT       7         number of netlist outputs passing through the unit
// MASK       7'h40     outputs flipped on key match (bit i -> y[i]); width NOUT
// MAX_LOADS  4         key_start events accepted after reset before lockout (>=1)
// PORTS
// clk          in   1     clock, all state on rising edge
// rst_n        in   1     asynchronous active-low reset
// key_start    in   1     begin (re)load of key register
// key_bit_vld  in   1     key_bit valid this cycle
// key_bit      in   1     serial key bit, MSB first
// key_ready    out  1     1 while in LOAD (bits accepted)
// key_armed    out  1     1 while in ARMED (restore enabled)
// locked_out   out  1     1 while in LOCKOUT
// in_valid     in   1     pi/y_enc sample valid
// pi           in   KW    protected primary inputs
// y_enc        in   NOUT  stripped-netlist outputs
// y            out  NOUT  restored outputs, registered
// out_valid    out  1     y updated this cycle
// BEHAVIOUR
// - Reset (async assert, sync release): state=IDLE, key_reg=0, bit_cnt=0, load_cnt=0, y=0, out_valid=0.
// - FSM states: IDLE, LOAD, ARMED, LOCKOUT. Outputs key_ready/key_armed/locked_out decode the state, registered.
// - IDLE/LOAD/ARMED on key_start:
//   - if load_cnt==MAX_LOADS -> LOCKOUT;
//   - else -> LOAD with key_reg=0, bit_cnt=0, load_cnt+1.
// - LOAD on key_bit_vld (without key_start): key_reg <= {key_reg[KW-2:0],key_bit}, bit_cnt+1.
//   - The bit that makes bit_cnt reach KW moves the FSM to ARMED in the same edge.
//   - bit_cnt width = $clog2(KW+1).
// - key_start and key_bit_vld in the same cycle: key_start wins, the bit is discarded.
// - key_bit_vld outside LOAD is ignored. LOCKOUT ignores everything; only rst_n exits it.
// - match = (state==ARMED) && (pi == key_reg), full KW-bit equality.
// - Datapath, latency 1:
//   - if in_valid: y <= y_enc ^ (match ? MASK : 0), out_valid <= 1;
//   - else y holds and out_valid <= 0.
// - match uses the state before the edge, so a sample in the cycle that completes the load is NOT restored.
// - In IDLE/LOAD/LOCKOUT, y = y_enc registered unchanged, so the stripped point stays corrupted.
// - A reload from ARMED disables restore from the next cycle; the old key is cleared at once.
// - No combinational path from pi, y_enc or key inputs to any output.
// - rst_n asserted mid-load or mid-stream: immediate return to reset values; partial key is lost.
// TESTING
// - Reset, then in_valid=1, y_enc=7'h55, pi=any -> after 1 clk y=7'h55, out_valid=1, key_armed=0.
// - key_start, then 32 bits of 0xA5A55A5A MSB-first -> key_armed=1 after the 32nd bit.
//   - Next, pi=0xA5A55A5A, y_enc=7'h55 -> y=7'h15.
//   - pi=0xA5A55A5B -> y=7'h55.
// - Load key 0x0000FFFF, but pulse key_start together with bit 20 -> restart.
//   - key_armed stays 0 until 32 further bits; matching pi before then -> y=y_enc.
// - Issue key_start 5 times (MAX_LOADS=4) -> 5th pulse gives locked_out=1.
//   - Correct key on pi -> y=y_enc; key_bit_vld ignored; rst_n low -> IDLE, locked_out=0.
// - Armed with key K, drop rst_n for 1 cycle mid-stream.
//   - y=0, out_valid=0 immediately; pi=K afterwards -> y=y_enc, no restore.
// - in_valid=0 for 3 cycles after a restored sample -> y holds 7'h15, out_valid=0.

Source files
------------

// File: rtl/cac_seq_restore_if.sv
// Signal bundle between the key loader / stripped netlist and the restore unit.
// The master side drives key bits and samples; the slave side is the restore unit.
interface cac_seq_restore_if #(
    parameter int KW   = 32,
    parameter int NOUT = 7
);
    logic            key_start;
    logic            key_bit_vld;
    logic            key_bit;
    logic            key_ready;
    logic            key_armed;
    logic            locked_out;
    logic            in_valid;
    logic [KW-1:0]   pi;
    logic [NOUT-1:0] y_enc;
    logic [NOUT-1:0] y;
    logic            out_valid;

    modport master (
        output key_start, key_bit_vld, key_bit, in_valid, pi, y_enc,
        input  key_ready, key_armed, locked_out, y, out_valid
    );

    modport slave (
        input  key_start, key_bit_vld, key_bit, in_valid, pi, y_enc,
        output key_ready, key_armed, locked_out, y, out_valid
    );
endinterface

// File: rtl/cac_seq_restore_unit.sv
// Sequential corrupt-and-correct restore stage: serially loaded key, registered
// restore of MASK-selected outputs on key match, with a bounded number of reloads.
module cac_seq_restore_unit #(
    parameter int              KW        = 32,
    parameter int              NOUT      = 7,
    parameter logic [NOUT-1:0] MASK      = 7'h40,
    parameter int              MAX_LOADS = 4
) (
    input  logic clk,
    input  logic rst_n,
    cac_seq_restore_if.slave bus
);
    localparam int CW = $clog2(KW + 1);
    localparam int LW = $clog2(MAX_LOADS + 1);

    typedef enum logic [1:0] {IDLE, LOAD, ARMED, LOCKOUT} state_t;

    state_t          state_reg, state_next;
    logic [KW-1:0]   key_reg, key_next;
    logic [CW-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [LW-1:0]   load_cnt_reg, load_cnt_next;
    logic            key_ready_reg, key_armed_reg, locked_out_reg;
    logic [NOUT-1:0] y_reg;
    logic            out_valid_reg;
    logic            match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            key_reg        <= '0;
            bit_cnt_reg    <= '0;
            load_cnt_reg   <= '0;
            key_ready_reg  <= 1'b0;
            key_armed_reg  <= 1'b0;
            locked_out_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            key_reg        <= key_next;
            bit_cnt_reg    <= bit_cnt_next;
            load_cnt_reg   <= load_cnt_next;
            // Status flags track the state register exactly, without a decode path.
            key_ready_reg  <= (state_next == LOAD);
            key_armed_reg  <= (state_next == ARMED);
            locked_out_reg <= (state_next == LOCKOUT);
        end
    end

    always_comb begin
        state_next    = state_reg;
        key_next      = key_reg;
        bit_cnt_next  = bit_cnt_reg;
        load_cnt_next = load_cnt_reg;
        if (state_reg != LOCKOUT) begin
            // key_start has priority over a coincident key bit, which is dropped.
            if (bus.key_start) begin
                if (load_cnt_reg == LW'(MAX_LOADS)) begin
                    state_next = LOCKOUT;
                    key_next   = '0;
                end else begin
                    state_next    = LOAD;
                    key_next      = '0;
                    bit_cnt_next  = '0;
                    load_cnt_next = load_cnt_reg + 1'b1;
                end
            end else if (state_reg == LOAD && bus.key_bit_vld) begin
                key_next     = {key_reg[KW-2:0], bus.key_bit};
                bit_cnt_next = bit_cnt_reg + 1'b1;
                if (bit_cnt_reg == CW'(KW - 1)) begin
                    state_next = ARMED;
                end
            end
        end
    end

    // Uses the pre-edge state, so the sample coinciding with the last key bit stays corrupted.
    assign match = (state_reg == ARMED) && (bus.pi == key_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_reg         <= '0;
            out_valid_reg <= 1'b0;
        end else if (bus.in_valid) begin
            y_reg         <= bus.y_enc ^ (match ? MASK : '0);
            out_valid_reg <= 1'b1;
        end else begin
            out_valid_reg <= 1'b0;
        end
    end

    assign bus.key_ready  = key_ready_reg;
    assign bus.key_armed  = key_armed_reg;
    assign bus.locked_out = locked_out_reg;
    assign bus.y          = y_reg;
    assign bus.out_valid  = out_valid_reg;
endmodule

// File: tb/tb_cac_seq_restore_unit.sv
// Randomised scoreboard bench for cac_seq_restore_unit against a behavioural key/restore model.
module tb_cac_seq_restore_unit;
    localparam int         KW   = 32;
    localparam int         NOUT = 7;
    localparam int         MAXL = 4;
    localparam logic [6:0] MASK = 7'h40;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cac_seq_restore_if #(.KW(KW), .NOUT(NOUT)) bus();

    cac_seq_restore_unit #(.KW(KW), .NOUT(NOUT), .MASK(MASK), .MAX_LOADS(MAXL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [6:0] exp_q[$];

    // Reference model: what the key holder knows and whether restore is enabled.
    bit          m_loading, m_armed, m_locked;
    int          m_nbits, m_loads;
    logic [31:0] m_key;
    logic [6:0]  m_last_y;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        m_loading = 0; m_armed = 0; m_locked = 0;
        m_nbits = 0; m_loads = 0; m_key = '0; m_last_y = '0;
    endtask

    // Called at a negedge; applies one cycle of stimulus and returns at the next negedge.
    task automatic step(bit ks, bit kv, bit kb, bit iv, logic [31:0] p, logic [6:0] ye);
        logic [6:0] e;
        bit hit;
        bus.key_start = ks; bus.key_bit_vld = kv; bus.key_bit = kb;
        bus.in_valid = iv; bus.pi = p; bus.y_enc = ye;
        hit = m_armed && (p == m_key);
        if (iv) begin
            e = hit ? (ye ^ MASK) : ye;
            exp_q.push_back(e);
            m_last_y = e;
        end
        if (!m_locked) begin
            if (ks) begin
                if (m_loads == MAXL) begin
                    m_locked = 1; m_loading = 0; m_armed = 0;
                end else begin
                    m_loading = 1; m_armed = 0; m_key = '0; m_nbits = 0; m_loads++;
                end
            end else if (kv && m_loading) begin
                m_key = {m_key[30:0], kb};
                m_nbits++;
                if (m_nbits == KW) begin
                    m_loading = 0; m_armed = 1;
                end
            end
        end
        @(posedge clk); #1;
        chk("key_ready", bus.key_ready, m_loading);
        chk("key_armed", bus.key_armed, m_armed);
        chk("locked_out", bus.locked_out, m_locked);
        if (!iv) begin
            chk("out_valid_idle", bus.out_valid, 0);
            chk("y_hold", bus.y, m_last_y);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 0;
        bus.key_start = 0; bus.key_bit_vld = 0; bus.key_bit = 0;
        bus.in_valid = 0; bus.pi = '0; bus.y_enc = '0;
        #1;
        chk("rst_y", bus.y, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_flags", {bus.key_ready, bus.key_armed, bus.locked_out}, 0);
        chk("rst_pending", exp_q.size(), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic load_key(logic [31:0] k, logic [6:0] ye);
        step(1, 0, 0, 0, '0, '0);
        for (int i = 31; i >= 0; i--)
            step(0, 1, k[i], 1, (i == 0) ? k : $urandom, ye);
    endtask

    // Monitor: pops one expectation per presented output.
    initial begin
        logic [6:0] e;
        forever begin
            @(posedge clk); #1;
            if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_out: got y=%h expected no output", bus.y);
                end else begin
                    e = exp_q.pop_front();
                    chk("y", bus.y, e);
                    $display("out y=%h exp=%h", bus.y, e);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] k;
        model_reset();
        @(negedge clk);
        do_reset();

        // Unarmed pass-through.
        step(0, 0, 0, 1, $urandom, 7'h55);
        chk("pass_y", bus.y, 7'h55);

        // Load and restore, then hold for three idle cycles.
        load_key(32'hA5A55A5A, 7'h55);
        step(0, 0, 0, 1, 32'hA5A55A5A, 7'h55);
        chk("restored", bus.y, 7'h15);
        step(0, 0, 0, 1, 32'hA5A55A5B, 7'h55);
        chk("near_miss", bus.y, 7'h55);
        step(0, 0, 0, 1, 32'hA5A55A5A, 7'h55);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 32'hA5A55A5A, 7'h2A);
        chk("hold_15", bus.y, 7'h15);

        // Reload from ARMED, aborted by key_start coincident with bit 20.
        k = 32'h0000FFFF;
        step(1, 0, 0, 1, 32'hA5A55A5A, 7'h55);
        for (int i = 31; i > 11; i--) step(0, 1, k[i], 1, k, 7'h7F);
        step(1, 1, k[11], 1, k, 7'h7F);
        for (int i = 31; i >= 0; i--) step(0, 1, k[i], 1, k, 7'h3C);
        step(0, 0, 0, 1, k, 7'h3C);
        chk("restart_restored", bus.y, 7'h7C);

        // Randomised traffic.
        do_reset();
        load_key($urandom, $urandom);
        for (int i = 0; i < 250; i++)
            step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
                 1'($urandom), $urandom_range(0, 1) ? m_key : $urandom, 7'($urandom));

        // Lockout after MAX_LOADS reloads.
        do_reset();
        k = $urandom;
        load_key(k, 7'h11);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1, k, 7'h22);
        chk("locked", bus.locked_out, 1);
        step(0, 0, 0, 1, k, 7'h4B);
        chk("locked_no_restore", bus.y, 7'h4B);
        for (int i = 0; i < 4; i++) step(i == 2, 1, 1'($urandom), 1, k, 7'($urandom));
        do_reset();

        // Reset mid-stream loses the key.
        k = $urandom;
        load_key(k, 7'h09);
        step(0, 0, 0, 1, k, 7'h09);
        chk("pre_rst_restored", bus.y, 7'h49);
        do_reset();
        step(0, 0, 0, 1, k, 7'h09);
        chk("post_rst_plain", bus.y, 7'h09);

        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
